// File: rtl/seg7_scan_ctrl_pkg.sv
// rtl/seg7_scan_ctrl_pkg.sv - shared state codes and constants for the 7-segment scanner
package seg7_scan_ctrl_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHOW  = 2'd1;
  localparam state_t ST_BLANK = 2'd2;

  // All segments off (active-low)
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/seg7dec.sv
// rtl/seg7dec.sv - hex nibble to active-low gfedcba segment decoder
module seg7dec (
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = 7'h7F;
    case (hex_i)
      4'h0: seg_o = 7'h40;
      4'h1: seg_o = 7'h79;
      4'h2: seg_o = 7'h24;
      4'h3: seg_o = 7'h30;
      4'h4: seg_o = 7'h19;
      4'h5: seg_o = 7'h12;
      4'h6: seg_o = 7'h02;
      4'h7: seg_o = 7'h78;
      4'h8: seg_o = 7'h00;
      4'h9: seg_o = 7'h10;
      4'hA: seg_o = 7'h08;
      4'hB: seg_o = 7'h03;
      4'hC: seg_o = 7'h46;
      4'hD: seg_o = 7'h21;
      4'hE: seg_o = 7'h06;
      4'hF: seg_o = 7'h0E;
      default: seg_o = 7'h7F;
    endcase
  end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// rtl/seg7_scan_ctrl.sv - multiplexed 7-segment scan controller with frame-aligned value commit
module seg7_scan_ctrl
  import seg7_scan_ctrl_pkg::*;
#(
  parameter int N_DIGITS  = 8,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    wr_en,
  input  logic [4*N_DIGITS-1:0]   wr_data,
  input  logic                    blank_lz,
  output logic [6:0]              nhex,
  output logic [N_DIGITS-1:0]     an_n,
  output logic                    pending,
  output logic                    frame_done
);

  localparam int CNT_W = $clog2(max_int(SCAN_DIV, BLANK_CYC)) + 1;
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int DW    = 4 * N_DIGITS;

  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]       disp_q, disp_d;
  logic [DW-1:0]       pend_q, pend_d;
  logic                pending_q, pending_d;
  logic                fd_q, fd_d;
  logic [N_DIGITS-1:0] an_n_q, an_n_d;
  logic [6:0]          nhex_q, nhex_d;
  logic                wrap;
  logic                lz_blank;
  logic [3:0]          nibble;
  logic [6:0]          seg;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    wrap    = 1'b0;
    if (!en) begin
      state_d = ST_IDLE;
      idx_d   = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          idx_d   = '0;
          cnt_d   = '0;
        end
        ST_SHOW: begin
          if (cnt_q == SHOW_LAST) begin
            state_d = ST_BLANK;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_SHOW;
            cnt_d   = '0;
            if (idx_q == IDX_LAST) begin
              idx_d = '0;
              wrap  = 1'b1;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
    fd_d = wrap;
  end

  // Writes while scanning are staged so a frame never shows a mix of old and new digits
  always_comb begin
    disp_d    = disp_q;
    pend_d    = pend_q;
    pending_d = pending_q;
    if (state_q == ST_IDLE) begin
      if (wr_en) begin
        disp_d    = wr_data;
        pending_d = 1'b0;
      end
    end else if (wrap) begin
      if (wr_en) begin
        disp_d    = wr_data;
        pending_d = 1'b0;
      end else if (pending_q) begin
        disp_d    = pend_q;
        pending_d = 1'b0;
      end
    end else if (wr_en) begin
      pend_d    = wr_data;
      pending_d = 1'b1;
    end
  end

  assign nibble = disp_d[{idx_d, 2'b00} +: 4];

  seg7dec u_dec (
    .hex_i (nibble),
    .seg_o (seg)
  );

  // Outputs are computed from next state so they line up with the registered state
  always_comb begin
    lz_blank = blank_lz && (idx_d != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(idx_d) && disp_d[4*i +: 4] != 4'h0) begin
        lz_blank = 1'b0;
      end
    end
    an_n_d = '1;
    nhex_d = SEG_BLANK;
    if (state_d == ST_SHOW) begin
      an_n_d[idx_d] = 1'b0;
      if (!lz_blank) begin
        nhex_d = seg;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      cnt_q     <= '0;
      disp_q    <= '0;
      pend_q    <= '0;
      pending_q <= 1'b0;
      fd_q      <= 1'b0;
      an_n_q    <= '1;
      nhex_q    <= SEG_BLANK;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      cnt_q     <= cnt_d;
      disp_q    <= disp_d;
      pend_q    <= pend_d;
      pending_q <= pending_d;
      fd_q      <= fd_d;
      an_n_q    <= an_n_d;
      nhex_q    <= nhex_d;
    end
  end

  assign nhex       = nhex_q;
  assign an_n       = an_n_q;
  assign pending    = pending_q;
  assign frame_done = fd_q;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// tb/tb_seg7_scan_ctrl.sv - directed self-checking bench for seg7_scan_ctrl
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 4;
  localparam int BC    = 2;
  localparam int SLOT  = SD + BC;
  localparam int FRAME = ND * SLOT;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        wr_en;
  logic [15:0] wr_data;
  logic        blank_lz;
  logic [6:0]  nhex;
  logic [3:0]  an_n;
  logic        pending;
  logic        frame_done;

  int          n_checks = 0;
  int          n_errors = 0;
  int          pos;
  logic [15:0] m_disp;
  logic [15:0] m_pend;
  logic        m_pending;

  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .N_DIGITS  (ND),
    .SCAN_DIV  (SD),
    .BLANK_CYC (BC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .blank_lz   (blank_lz),
    .nhex       (nhex),
    .an_n       (an_n),
    .pending    (pending),
    .frame_done (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s pos=%0d t=%0t: got %0h expected %0h", tag, pos, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag, input logic exp_pend);
    check({tag, ".an_n"}, 32'(an_n), 32'h0000_000F);
    check({tag, ".nhex"}, 32'(nhex), 32'h0000_007F);
    check({tag, ".frame_done"}, 32'(frame_done), 32'h0);
    check({tag, ".pending"}, 32'(pending), 32'(exp_pend));
  endtask

  task automatic check_scan();
    int          p;
    int          d;
    int          r;
    logic [3:0]  an_e;
    logic [6:0]  seg_e;
    logic [15:0] hi;
    logic        fd_e;
    p     = pos % FRAME;
    d     = p / SLOT;
    r     = p % SLOT;
    an_e  = 4'hF;
    seg_e = 7'h7F;
    if (r < SD) begin
      an_e = ~(4'(1) << d);
      hi   = m_disp >> (4 * d);
      if (!(blank_lz && d > 0 && hi == 16'h0)) seg_e = seg_tab[m_disp[4*d +: 4]];
    end
    fd_e = (pos > 0 && p == 0);
    check("scan.an_n", 32'(an_n), 32'(an_e));
    check("scan.nhex", 32'(nhex), 32'(seg_e));
    check("scan.frame_done", 32'(frame_done), 32'(fd_e));
    check("scan.pending", 32'(pending), 32'(m_pending));
  endtask

  task automatic step_m(input logic wr, input logic [15:0] data);
    wr_en   = wr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
    pos++;
    if (pos % FRAME == 0) begin
      if (wr) begin
        m_disp    = data;
        m_pending = 1'b0;
      end else if (m_pending) begin
        m_disp    = m_pend;
        m_pending = 1'b0;
      end
    end else if (wr) begin
      m_pend    = data;
      m_pending = 1'b1;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      check_scan();
      step_m(1'b0, 16'h0);
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; wr_data = 16'h0; blank_lz = 1'b0;
    m_disp = 16'h0; m_pend = 16'h0; m_pending = 1'b0; pos = 0;
    tick();
    tick();
    check_idle("reset", 1'b0);

    // IDLE write with enable: full frames including the wrap pulse
    rst = 1'b0; en = 1'b1; wr_en = 1'b1; wr_data = 16'h1234;
    tick();
    wr_en = 1'b0; pos = 0; m_disp = 16'h1234; m_pending = 1'b0;
    run(30);

    // Mid-frame write held until wrap
    step_m(1'b1, 16'hABCD);
    run(24);

    // Write landing on the wrap edge beats the staged value
    step_m(1'b1, 16'h1111);
    run(15);
    step_m(1'b1, 16'h9999);
    run(9);

    // Drop enable in digit 2 with a write staged
    step_m(1'b1, 16'h2222);
    run(2);
    check_scan();
    en = 1'b0;
    tick();
    check_idle("en_drop", 1'b1);
    tick();
    check_idle("idle_hold", 1'b1);

    // Re-enable without a write: staged value commits at the first wrap
    en = 1'b1;
    tick();
    pos = 0;
    run(30);

    // IDLE write with enable low, then leading-zero blanking
    en = 1'b0;
    tick();
    check_idle("idle_enter", 1'b0);
    blank_lz = 1'b1; wr_en = 1'b1; wr_data = 16'h0005;
    tick();
    wr_en = 1'b0; m_disp = 16'h0005;
    check_idle("idle_write", 1'b0);
    en = 1'b1;
    tick();
    pos = 0;
    run(26);

    // Reset during BLANK with a staged write
    step_m(1'b1, 16'h7777);
    run(1);
    check_scan();
    rst = 1'b1;
    tick();
    check_idle("rst_blank", 1'b0);
    rst = 1'b0; m_disp = 16'h0; m_pending = 1'b0;
    tick();
    pos = 0;
    run(12);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
